// File: rtl/seg_scan_ctrl_pkg.sv
// Shared definitions for the seven-segment scan controller: panel size,
// active-low segment codes and the controller FSM state type.
package seg_pkg;

    localparam int unsigned NUM_DIGITS = 6;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_SRC0  = 8'h40;  // "0" with dp lit
    localparam logic [7:0] SEG_SRC1  = 8'h79;  // "1" with dp lit

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        LOAD = 2'd2
    } state_e;

    function automatic logic [7:0] digit_seg(input logic [3:0] d);
        case (d)
            4'd0:    return 8'hC0;
            4'd1:    return 8'hF9;
            4'd2:    return 8'hA4;
            4'd3:    return 8'hB0;
            4'd4:    return 8'h99;
            4'd5:    return 8'h92;
            4'd6:    return 8'h82;
            4'd7:    return 8'hF8;
            4'd8:    return 8'h80;
            4'd9:    return 8'h90;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_bin2bcd_seq.sv
// Sequential double-dabble: 8-bit binary to three BCD digits in 8 cycles.
// start_i loads the operand; done_o is high on the cycle of the final shift.
module bin2bcd_seq (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start_i,
    input  logic [7:0]  din_i,
    output logic        done_o,
    output logic [11:0] bcd_o
);

    logic [19:0] sr_q, sr_d;
    logic [19:0] adj;
    logic [2:0]  cnt_q, cnt_d;
    logic        run_q, run_d;

    always_comb begin
        adj = sr_q;
        for (int unsigned i = 0; i < 3; i++) begin
            if (sr_q[8 + 4*i +: 4] >= 4'd5) begin
                adj[8 + 4*i +: 4] = sr_q[8 + 4*i +: 4] + 4'd3;
            end
        end

        sr_d  = sr_q;
        cnt_d = cnt_q;
        run_d = run_q;
        if (start_i) begin
            sr_d  = {12'd0, din_i};
            cnt_d = '0;
            run_d = 1'b1;
        end else if (run_q) begin
            sr_d  = {adj[18:0], 1'b0};
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
                run_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sr_q  <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

    assign done_o = run_q && (cnt_q == 3'd7);
    assign bcd_o  = sr_q[19:8];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Two-requester round-robin display controller: accepts an 8-bit value,
// converts it to BCD and scans it onto a six-digit common-anode panel.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned DWELL = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req0_valid,
    input  logic [7:0]            req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [7:0]            req1_data,
    output logic                  req1_ready,
    output logic                  busy,
    output logic [NUM_DIGITS-1:0] sel,
    output logic [7:0]            seg_out
);

    localparam logic [19:0] DWELL_LAST = 20'(DWELL - 1);
    localparam logic [2:0]  LAST_DIGIT = 3'(NUM_DIGITS - 1);

    state_e                state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic                  src_q, src_d;
    logic                  grant0, grant1;
    logic                  conv_start, conv_done, load;
    logic [11:0]           bcd;
    logic [3:0]            hund_q, tens_q, ones_q;
    logic                  buf_src_q, shown_q;
    logic [19:0]           dwell_q, dwell_d;
    logic [2:0]            idx_q, idx_d;
    logic [NUM_DIGITS-1:0] sel_q, sel_d;
    logic [7:0]            seg_q, seg_d;

    // last_grant_q = 1 means requester 1 was served last, so requester 0 wins a tie
    assign grant0 = req0_valid && (!req1_valid || last_grant_q);
    assign grant1 = req1_valid && (!req0_valid || !last_grant_q);

    assign req0_ready = (state_q == IDLE) && grant0;
    assign req1_ready = (state_q == IDLE) && grant1;
    assign busy       = (state_q != IDLE);

    bin2bcd_seq u_bin2bcd (
        .clk     (clk),
        .reset_n (reset_n),
        .start_i (conv_start),
        .din_i   (grant1 ? req1_data : req0_data),
        .done_o  (conv_done),
        .bcd_o   (bcd)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        src_d        = src_q;
        conv_start   = 1'b0;
        load         = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant0 || grant1) begin
                    conv_start = 1'b1;
                    src_d      = grant1;
                    state_d    = CONV;
                end
            end
            CONV: begin
                if (conv_done) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                load         = 1'b1;
                last_grant_d = src_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            src_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            src_q        <= src_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hund_q    <= '0;
            tens_q    <= '0;
            ones_q    <= '0;
            buf_src_q <= 1'b0;
            shown_q   <= 1'b0;
        end else if (load) begin
            hund_q    <= bcd[11:8];
            tens_q    <= bcd[7:4];
            ones_q    <= bcd[3:0];
            buf_src_q <= src_q;
            shown_q   <= 1'b1;
        end
    end

    always_comb begin
        dwell_d = dwell_q + 20'd1;
        idx_d   = idx_q;
        if (dwell_q == DWELL_LAST) begin
            dwell_d = '0;
            idx_d   = (idx_q == LAST_DIGIT) ? '0 : idx_q + 3'd1;
        end

        sel_d = ~(NUM_DIGITS'(1) << idx_q);
        case (idx_q)
            3'd0:    seg_d = digit_seg(ones_q);
            3'd1:    seg_d = (hund_q == 4'd0 && tens_q == 4'd0) ? SEG_BLANK : digit_seg(tens_q);
            3'd2:    seg_d = (hund_q == 4'd0) ? SEG_BLANK : digit_seg(hund_q);
            3'd5:    seg_d = !shown_q ? SEG_BLANK : (buf_src_q ? SEG_SRC1 : SEG_SRC0);
            default: seg_d = SEG_BLANK;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dwell_q <= '0;
            idx_q   <= '0;
            sel_q   <= '1;
            seg_q   <= SEG_BLANK;
        end else begin
            dwell_q <= dwell_d;
            idx_q   <= idx_d;
            sel_q   <= sel_d;
            seg_q   <= seg_d;
        end
    end

    assign sel     = sel_q;
    assign seg_out = seg_q;

endmodule
